key_search_ctrl: RTL
====================

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 Parameter: N, default 32, key/entry width in bits.
REQ-002 Parameter: DEPTH, default 16, maximum table entries searchable.
REQ-003 Parameter: A, default $clog2(DEPTH), address width.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  search request; sampled only in IDLE.
REQ-007 Port: key  input  N  search key; captured with start.
REQ-008 Port: count  input  A+1  number of entries to search (0..DEPTH); captured with start.
REQ-009 Port: mem_rd  output  1  table read strobe.
REQ-010 Port: mem_addr  output  A  table read address.
REQ-011 Port: mem_rdata  input  N  table data; valid exactly one cycle after mem_rd.
REQ-012 Port: busy  output  1  high while a search is in progress.
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: hit  output  1  last search found the key.
REQ-015 Port: hit_index  output  A  index of first matching entry; 0 on miss.

Function
REQ-016 FSM states SHALL be IDLE, READ, COMPARE, DONE; all outputs registered or decoded from registered state only.
REQ-017 IDLE: start=1 SHALL latch key into key_q, min(count,DEPTH) into cnt_q, clear idx to 0; next state READ, or DONE if captured count is 0.
REQ-018 READ: mem_rd=1, mem_addr=idx; next state COMPARE unconditionally.
REQ-019 COMPARE: mem_rdata SHALL be compared against key_q for bitwise equality; match -> DONE with hit=1, hit_index=idx.
REQ-020 COMPARE, no match: if idx+1 == cnt_q -> DONE with hit=0, hit_index=0; else idx increments, next state READ.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-022 Latency: match at index i -> done high in cycle 2i+3 after the start edge; full miss over C>0 entries -> cycle 2C+1; C=0 -> cycle 1.
REQ-023 busy SHALL be 1 in READ and COMPARE only; 0 in IDLE and DONE.
REQ-024 mem_rd SHALL be 0 outside READ; mem_addr holds its last value outside READ.
REQ-025 start while not IDLE (including DONE) SHALL be ignored; key/count changes after capture have no effect.
REQ-026 hit and hit_index SHALL hold their values from DONE until the next accepted start, at which point both clear to 0.
REQ-027 First match wins; later duplicates SHALL not alter hit_index.
REQ-028 count > DEPTH SHALL be clamped to DEPTH; idx never exceeds DEPTH-1.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state IDLE, idx=0, key_q=0, cnt_q=0.
REQ-030 During reset, mem_rd, busy, done, hit SHALL be 0 and mem_addr, hit_index SHALL be 0.
REQ-031 Reset asserted mid-search SHALL abort it without a done pulse; the first start after rst_n deasserts begins a fresh search.

Structure
REQ-032 Package key_search_pkg SHALL hold the state enum (IDLE, READ, COMPARE, DONE) and the default N/DEPTH constants.
REQ-033 Equality SHALL be computed by one instance of the team's structural comparator_eq (parameter N) on key_q and mem_rdata; no other comparator of width N.
REQ-034 idx/cnt_q compare is A+1 bits wide to represent count=DEPTH without wrap.

Verification
REQ-035 Reset mid-search: assert rst_n=0 during COMPARE -> all outputs 0 same cycle, no done; new start after release -> normal search.
REQ-036 Hit: table[0..15]=i*3, key=0x15, count=16 -> done in cycle 17, hit=1, hit_index=7, mem_rd pulsed at addrs 0..7 only.
REQ-037 Miss: same table, key=0xFFFF_FFFF, count=16 -> done in cycle 33, hit=0, hit_index=0, busy high cycles 1..32.
REQ-038 Boundaries: count=0 -> done cycle 1, hit=0, mem_rd never asserted; count=20 -> behaves as 16; key at index 15 -> hit_index=15.
REQ-039 Duplicates and ignored start: table[2]=table[9]=key -> hit_index=2; pulse start with new key while busy -> result unchanged, done pulses once.
REQ-040 Back-to-back: start asserted in the cycle after DONE -> accepted; hit/hit_index cleared on acceptance, second result correct.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared definitions for the key search controller: FSM state encoding and
// default key width / table depth.
package key_search_pkg;

    localparam int KS_N     = 32;
    localparam int KS_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/key_search_ctrl_comparator_eq.sv
// Structural N-bit equality comparator: per-bit XNOR followed by an AND reduction.
module comparator_eq #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);

    logic [N-1:0] same;

    assign same = ~(a ^ b);
    assign eq   = &same;

endmodule

// File: rtl/key_search_ctrl.sv
// Linear key search over an external table with one-cycle read latency.
// Reports the first matching index, or a miss, with a one-cycle done pulse.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int N     = KS_N,
    parameter int DEPTH = KS_DEPTH,
    parameter int A     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] key,
    input  logic [A:0]   count,
    output logic         mem_rd,
    output logic [A-1:0] mem_addr,
    input  logic [N-1:0] mem_rdata,
    output logic         busy,
    output logic         done,
    output logic         hit,
    output logic [A-1:0] hit_index
);

    // Index and count are one bit wider than the address so count == DEPTH
    // can be represented without wrapping.
    localparam logic [A:0] DEPTH_W = (A+1)'(DEPTH);

    state_t       state;
    logic [N-1:0] key_q;
    logic [A:0]   cnt_q;
    logic [A:0]   idx;
    logic [A:0]   idx_next;
    logic         match;

    assign idx_next = idx + 1'b1;

    comparator_eq #(.N(N)) u_eq (
        .a  (key_q),
        .b  (mem_rdata),
        .eq (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_q     <= '0;
            cnt_q     <= '0;
            idx       <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            hit_index <= '0;
        end else begin
            mem_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q     <= key;
                        cnt_q     <= (count > DEPTH_W) ? DEPTH_W : count;
                        idx       <= '0;
                        hit       <= 1'b0;
                        hit_index <= '0;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= READ;
                            mem_rd   <= 1'b1;
                            mem_addr <= '0;
                            busy     <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (match) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        hit       <= 1'b1;
                        hit_index <= idx[A-1:0];
                    end else if (idx_next == cnt_q) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        hit       <= 1'b0;
                        hit_index <= '0;
                    end else begin
                        idx      <= idx_next;
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= idx_next[A-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
